ut_param: RTL and testbench
===========================

UT_PARAM -- requirements
Module: ut_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: datapath width in bits; legal values 4..32.
REQ-002 SHALL have parameter NREG, default 4: number of operand registers R[0..NREG-1]; legal values 2..16; RSW = clog2(NREG).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ce, input, 1 bit: clock enable; when 0, all state holds.
REQ-006 SHALL have port sel_ual, input, 3 bits: ALU operation select.
REQ-007 SHALL have port r_sel, input, RSW bits: operand register index, used for both read and write.
REQ-008 SHALL have port load_r, input, 1 bit: write data_in into R[r_sel].
REQ-009 SHALL have port load_accu, input, 1 bit: load the ALU result into the accumulator.
REQ-010 SHALL have port load_carry, input, 1 bit: load the ALU carry-out into the carry flag.
REQ-011 SHALL have port init_carry, input, 1 bit: clear the carry flag.
REQ-012 SHALL have port data_in, input, WIDTH bits: register write data.
REQ-013 SHALL have port data_out, output, WIDTH bits: accumulator value, driven directly from the register.
REQ-014 SHALL have port carry, output, 1 bit: carry flag, driven directly from the register.
REQ-015 SHALL have port zero, output, 1 bit: 1 when the accumulator equals 0; combinational from the accumulator.
REQ-016 SHALL have port busy, output, 1 bit: multi-cycle operation in progress.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when a multi-cycle operation completes.

Function
REQ-018 SHALL define A = accumulator, B = R[r_sel], Ci = carry flag.
REQ-019 SHALL compute combinational ALU results for each sel_ual value:
  - 000: result B, carry-out 0.
  - 001: A+B+Ci; carry-out = bit WIDTH of the sum.
  - 010: A-B-(~Ci) (borrow convention); carry-out = 1 when no borrow.
  - 011: A&B, carry-out 0.
  - 100: A|B, carry-out 0.
  - 101: A^B, carry-out 0.
  - 110: {A[WIDTH-2:0],Ci}; carry-out = A[WIDTH-1].
  - 111: see REQ-026/REQ-027.
REQ-020 SHALL perform all register updates only on a rising clk edge with ce=1.
REQ-021 SHALL, when load_r=1, write data_in into R[r_sel].
REQ-022 SHALL use the pre-edge value of R when load_r and load_accu are asserted in the same cycle.
REQ-023 SHALL, when r_sel >= NREG: ignore writes; reads return 0.
REQ-024 SHALL give init_carry priority over load_carry: carry <= 0 when both are asserted.
REQ-025 SHALL keep a 2-state FSM, IDLE/MUL, for single-cycle ops:
  - IDLE only.
  - Result and carry load on the edge where load_accu / load_carry are sampled.
REQ-026 SHALL handle sel_ual=111 with load_accu=1 in IDLE as follows:
  - Latch A, B and the load_carry request.
  - Go to MUL; busy=1 for exactly WIDTH cycles of ce=1, one shift-add step per cycle.
  - On the final step: accu <= low WIDTH bits of A*B; if load_carry was latched, carry <= OR of the high WIDTH bits.
  - Return to IDLE; done=1 for one cycle.
REQ-027 SHALL treat ce=0 during MUL as a pause: step count and partial product hold, and done is not asserted.
REQ-028 SHALL, while busy=1, ignore load_r, load_accu, load_carry and init_carry.
REQ-029 SHALL not affect busy or the multiplier with sel_ual changes during MUL.

Reset
REQ-030 SHALL, on rst_n=0, immediately clear accu, carry, all R[i], busy, done and the step counter, and force IDLE, independent of clk and ce.
REQ-031 SHALL abort an in-progress multiply on reset: no done pulse, accu=0.
REQ-032 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-033 SHALL compile in the multiplier (REQ-026..REQ-029, MUL state) when macro UT_PARAM_MUL_EN is defined.
REQ-034 SHALL, without UT_PARAM_MUL_EN:
  - Make sel_ual=111 a single-cycle rotate right through carry: result {Ci,A[WIDTH-1:1]}, carry-out A[0].
  - Tie busy and done to 0.
  - Omit the MUL state.

Verification (WIDTH=8, NREG=4)
REQ-035 SHALL check add with carry: R1=0xF0, A=0x20, Ci=1, sel=001, load_accu+load_carry -> data_out=0x11, carry=1, zero=0.
REQ-036 SHALL check subtract: R2=0x05, A=0x05, init_carry then set Ci=1, sel=010, load_accu -> data_out=0x00, zero=1.
REQ-037 SHALL check same-cycle load_r and load_accu: R0=0x03; in one cycle load_r data_in=0x7F, sel=000 -> accu=0x03 and R0=0x7F afterwards.
REQ-038 SHALL check the multiply (MUL_EN): A=0x12, R3=0x10, sel=111, load_accu+load_carry, with one ce=0 cycle inserted:
  - busy=1 for 9 cycles.
  - done pulses once.
  - data_out=0x20, carry=1.
  - A load_r during busy leaves R unchanged.
REQ-039 SHALL check reset mid-multiply: assert rst_n=0 at step 4 -> busy=0 and accu=0 immediately; done never pulses.
REQ-040 SHALL check the no-MUL build: A=0x81, Ci=0, sel=111, load_accu+load_carry -> data_out=0x40, carry=1, busy=0.

Source files
------------

// File: rtl/ut_param.sv
// ============================================================================
// Module : ut_param
// Accumulator ALU over a small operand register file; the optional
// shift-add multiplier on sel_ual=111 is built when UT_PARAM_MUL_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ut_param #(
  parameter int  WIDTH = 8,
  parameter int  NREG  = 4,
  localparam int RSW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [2:0]       sel_ual,
  input  logic [RSW-1:0]   r_sel,
  input  logic             load_r,
  input  logic             load_accu,
  input  logic             load_carry,
  input  logic             init_carry,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] accu_q, accu_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] r_q [NREG];
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_co;

  // Unmatched indices (r_sel >= NREG) fall through and read as zero.
  always_comb begin
    opb = '0;
    for (int i = 0; i < NREG; i++) begin
      if (r_sel == i[RSW-1:0]) opb = r_q[i];
    end
  end

  assign sum = {1'b0, accu_q} + {1'b0, opb} + {{WIDTH{1'b0}}, carry_q};
  // A + ~B + Ci equals A - B - ~Ci, and bit WIDTH is the "no borrow" flag.
  assign dif = {1'b0, accu_q} + {1'b0, ~opb} + {{WIDTH{1'b0}}, carry_q};

  always_comb begin
    alu_res = opb;
    alu_co  = 1'b0;
    case (sel_ual)
      3'b001: begin alu_res = sum[WIDTH-1:0]; alu_co = sum[WIDTH]; end
      3'b010: begin alu_res = dif[WIDTH-1:0]; alu_co = dif[WIDTH]; end
      3'b011: alu_res = accu_q & opb;
      3'b100: alu_res = accu_q | opb;
      3'b101: alu_res = accu_q ^ opb;
      3'b110: begin alu_res = {accu_q[WIDTH-2:0], carry_q}; alu_co = accu_q[WIDTH-1]; end
`ifndef UT_PARAM_MUL_EN
      3'b111: begin alu_res = {carry_q, accu_q[WIDTH-1:1]}; alu_co = accu_q[0]; end
`endif
      default: ;
    endcase
  end

`ifdef UT_PARAM_MUL_EN
  localparam int            SW   = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_nxt;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               creq_q, creq_d;
  logic               done_q, done_d;
  logic [WIDTH:0]     psum;

  // Low half starts as the multiplier and drains out as the product shifts in.
  assign psum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nxt = {psum, prod_q[WIDTH-1:1]};
  assign busy     = (state_q == S_MUL);
  assign done     = done_q;
`else
  assign busy = 1'b0;
  assign done = 1'b0;
`endif

  always_comb begin
    accu_d  = accu_q;
    carry_d = carry_q;
`ifdef UT_PARAM_MUL_EN
    state_d = state_q;
    step_d  = step_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    creq_d  = creq_q;
    done_d  = 1'b0;
    if (state_q == S_MUL) begin
      prod_d = prod_nxt;
      step_d = step_q + 1'b1;
      if (step_q == LAST) begin
        accu_d  = prod_nxt[WIDTH-1:0];
        if (creq_q) carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
        step_d  = '0;
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end else if (load_accu && (sel_ual == 3'b111)) begin
      mcand_d = accu_q;
      prod_d  = {{WIDTH{1'b0}}, opb};
      creq_d  = load_carry;
      step_d  = '0;
      state_d = S_MUL;
    end else
`endif
    begin
      if (load_accu) accu_d = alu_res;
      if (init_carry)      carry_d = 1'b0;
      else if (load_carry) carry_d = alu_co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accu_q  <= '0;
      carry_q <= 1'b0;
`ifdef UT_PARAM_MUL_EN
      state_q <= S_IDLE;
      step_q  <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      creq_q  <= 1'b0;
      done_q  <= 1'b0;
`endif
    end else if (ce) begin
      accu_q  <= accu_d;
      carry_q <= carry_d;
`ifdef UT_PARAM_MUL_EN
      state_q <= state_d;
      step_q  <= step_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      creq_q  <= creq_d;
      done_q  <= done_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
    end else if (ce && !busy && load_r) begin
      for (int i = 0; i < NREG; i++) begin
        if (r_sel == i[RSW-1:0]) r_q[i] <= data_in;
      end
    end
  end

  assign data_out = accu_q;
  assign carry    = carry_q;
  assign zero     = (accu_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_ut_param.sv
// ============================================================================
// Module : tb_ut_param
// Self-checking bench for ut_param (WIDTH=8, NREG=4) against an arithmetic model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ut_param;
  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n, ce, load_r, load_accu, load_carry, init_carry;
  logic [2:0] sel_ual;
  logic [1:0] r_sel;
  logic [7:0] data_in, data_out;
  logic       carry, zero, busy, done;

  int n_pass  = 0;
  int n_total = 0;
  int m_accu, m_carry;
  int m_r [N];

  ut_param #(.WIDTH(W), .NREG(N)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sel_ual(sel_ual), .r_sel(r_sel),
    .load_r(load_r), .load_accu(load_accu), .load_carry(load_carry),
    .init_carry(init_carry), .data_in(data_in), .data_out(data_out),
    .carry(carry), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void alu_ref(input int sel, input int a, input int b, input int ci,
                                  output int res, output int co);
    int t;
    res = b;
    co  = 0;
    case (sel)
      1: begin t = a + b + ci; res = t % 256; co = t / 256; end
      2: begin t = a - b - (1 - ci); co = (t >= 0) ? 1 : 0; res = (t + 256) % 256; end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: begin res = (a * 2 + ci) % 256; co = a / 128; end
      7: begin res = ci * 128 + a / 2; co = a % 2; end
      default: ;
    endcase
  endfunction

  task automatic model_edge();
    int b, res, co;
    if (!ce) return;
    b = m_r[r_sel];
    alu_ref(int'(sel_ual), m_accu, b, m_carry, res, co);
    if (load_accu) m_accu = res;
    if (init_carry) m_carry = 0;
    else if (load_carry) m_carry = co;
    if (load_r) m_r[r_sel] = int'(data_in);
  endtask

  task automatic model_reset();
    m_accu = 0; m_carry = 0;
    for (int i = 0; i < N; i++) m_r[i] = 0;
  endtask

  task automatic idle_inputs();
    ce = 1'b1; sel_ual = 3'b000; r_sel = 2'd0; data_in = 8'h00;
    load_r = 1'b0; load_accu = 1'b0; load_carry = 1'b0; init_carry = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input int idx, input int val);
    idle_inputs();
    r_sel = 2'(idx); data_in = 8'(val); load_r = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic set_accu(input int val);
    write_reg(0, val);
    load_accu = 1'b1;
    tick();
    idle_inputs();
  endtask

  // Carry is set via the shift-left carry-out of a staged accumulator value.
  task automatic set_ac(input int a, input int c);
    set_accu(c != 0 ? 128 : 0);
    sel_ual = 3'b110; load_carry = 1'b1;
    tick();
    idle_inputs();
    set_accu(a);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_total++;
    if (data_out !== 8'h00 || carry !== 1'b0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset: data_out=%h carry=%b zero=%b busy=%b done=%b, required 00 0 1 0 0",
               data_out, carry, zero, busy, done);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    write_reg(1, 'hF0);
    set_ac('h20, 1);
    r_sel = 2'd1; sel_ual = 3'b001; load_accu = 1'b1; load_carry = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (data_out !== 8'h11 || carry !== 1'b1 || zero !== 1'b0)
      $display("FAIL add: data_out=%h carry=%b zero=%b, required 11 1 0", data_out, carry, zero);
    else n_pass++;

    write_reg(2, 'h05);
    set_ac('h05, 1);
    r_sel = 2'd2; sel_ual = 3'b010; load_accu = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (data_out !== 8'h00 || zero !== 1'b1 || carry !== 1'b1)
      $display("FAIL sub: data_out=%h zero=%b carry=%b, required 00 1 1", data_out, zero, carry);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    set_accu('h55);
    write_reg(0, 'h03);
    r_sel = 2'd0; sel_ual = 3'b000; load_r = 1'b1; data_in = 8'h7F; load_accu = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (data_out !== 8'h03)
      $display("FAIL same_cycle_accu: data_out=%h, required 03", data_out);
    else n_pass++;
    load_accu = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (data_out !== 8'h7F)
      $display("FAIL same_cycle_reg: R0=%h, required 7f", data_out);
    else n_pass++;
  endtask

  task automatic test_carry_priority();
    set_ac('hFF, 1);
    sel_ual = 3'b110; load_carry = 1'b1; init_carry = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (carry !== 1'b0 || data_out !== 8'hFF)
      $display("FAIL init_priority: carry=%b data_out=%h, required 0 ff", carry, data_out);
    else n_pass++;
  endtask

`ifdef UT_PARAM_MUL_EN
  task automatic test_mul(input int a, input int b);
    int busy_cnt, done_cnt, prod;
    prod = a * b;
    write_reg(3, b);
    set_ac(a, 0);
    r_sel = 2'd3; sel_ual = 3'b111; load_accu = 1'b1; load_carry = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    busy_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      ce = (k != 3);
      load_r = busy; load_accu = busy; load_carry = busy; init_carry = busy;
      r_sel = 2'd3; data_in = 8'hAA; sel_ual = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
    end
    idle_inputs();
    n_total++;
    if (busy_cnt != 9 || done_cnt != 1)
      $display("FAIL mul_timing: busy_cycles=%0d done_pulses=%0d, required 9 1", busy_cnt, done_cnt);
    else n_pass++;
    n_total++;
    if (data_out !== 8'(prod % 256) || carry !== ((prod >= 256) ? 1'b1 : 1'b0))
      $display("FAIL mul_result: %0d*%0d data_out=%h carry=%b, required %h %b",
               a, b, data_out, carry, 8'(prod % 256), (prod >= 256));
    else n_pass++;
    m_accu = prod % 256; m_carry = (prod >= 256) ? 1 : 0;
    r_sel = 2'd3; load_accu = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (data_out !== 8'(b))
      $display("FAIL mul_reg_hold: R3=%h, required %h", data_out, 8'(b));
    else n_pass++;
  endtask

  task automatic test_mul_reset();
    int done_cnt;
    write_reg(3, 'h77);
    set_ac('h99, 0);
    r_sel = 2'd3; sel_ual = 3'b111; load_accu = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || data_out !== 8'h00 || done !== 1'b0)
      $display("FAIL mul_reset: busy=%b data_out=%h done=%b, required 0 00 0", busy, data_out, done);
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    n_total++;
    if (done_cnt != 0)
      $display("FAIL mul_reset_after: busy/done seen %0d times, required 0", done_cnt);
    else n_pass++;
  endtask
`else
  task automatic test_rotate();
    set_ac('h81, 0);
    sel_ual = 3'b111; load_accu = 1'b1; load_carry = 1'b1;
    tick(); idle_inputs();
    n_total++;
    if (data_out !== 8'h40 || carry !== 1'b1 || busy !== 1'b0)
      $display("FAIL rotate: data_out=%h carry=%b busy=%b, required 40 1 0", data_out, carry, busy);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ce         = ($urandom_range(0, 9) != 0);
`ifdef UT_PARAM_MUL_EN
      sel_ual    = 3'($urandom_range(0, 6));
`else
      sel_ual    = 3'($urandom_range(0, 7));
`endif
      r_sel      = 2'($urandom_range(0, 3));
      data_in    = 8'($urandom_range(0, 255));
      load_r     = ($urandom_range(0, 2) == 0);
      load_accu  = ($urandom_range(0, 1) == 1);
      load_carry = ($urandom_range(0, 1) == 1);
      init_carry = ($urandom_range(0, 4) == 0);
      tick();
      n_total++;
      if (data_out !== 8'(m_accu) || carry !== 1'(m_carry) || zero !== (m_accu == 0) ||
          busy !== 1'b0 || done !== 1'b0)
        $display("FAIL random[%0d]: data_out=%h carry=%b zero=%b busy=%b done=%b, required %h %0d %0d 0 0",
                 k, data_out, carry, zero, busy, done, 8'(m_accu), m_carry, (m_accu == 0));
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    write_reg(1, 'h11); write_reg(2, 'h22); write_reg(3, 'h33);
    set_ac('h5A, 1);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (data_out !== 8'h00 || carry !== 1'b0 || zero !== 1'b1)
      $display("FAIL async_reset: data_out=%h carry=%b zero=%b, required 00 0 1", data_out, carry, zero);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_sel = 2'(i); load_accu = 1'b1;
      tick(); idle_inputs();
      n_total++;
      if (data_out !== 8'h00)
        $display("FAIL reg_reset[%0d]: R=%h, required 00", i, data_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_same_cycle();
    test_carry_priority();
`ifdef UT_PARAM_MUL_EN
    test_mul('h12, 'h10);
    for (int i = 0; i < 3; i++) test_mul(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    test_mul_reset();
`else
    test_rotate();
`endif
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
